// File: rtl/complex_operand_seq.sv
// complex_operand_seq: splits one complex multiply into two beats of packed
// FP64 operand pairs for a dual-lane downstream multiplier.
//   beat 0 (direct): {A.re, A.im, B.re, B.im}
//   beat 1 (cross) : {A.re, A.im, B.im, B.re}
// Optional feature macro: COMPLEX_OPERAND_SEQ_CONJ_EN adds conj_i. When it is
// set, the sign of B.im is inverted at capture, so the products form A*conj(B).
//
// state | meaning
// IDLE  | nothing held, ready for a new operation
// BEAT0 | presenting the direct-product operands
// BEAT1 | presenting the cross-product operands; may accept the next op
module complex_operand_seq #(
  parameter int TAG_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0][63:0]      cplx_a_i,
  input  logic [1:0][63:0]      cplx_b_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
`ifdef COMPLEX_OPERAND_SEQ_CONJ_EN
  input  logic                  conj_i,
`endif
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  output logic [3:0][63:0]      operands_o,
  output logic                  beat_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0][63:0]       a_q, a_d;
  logic [1:0][63:0]       b_q, b_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   accept;

  // State and operand registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
    end
  end

  // Next-state, capture and handshake logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;

    // Reset also blocks acceptance so nothing is captured during rst_i.
    in_ready_o = ((state_q == IDLE) || ((state_q == BEAT1) && out_ready_i))
                 && !flush_i && !rst_i;
    accept     = in_valid_i && in_ready_o;

    case (state_q)
      IDLE:    if (accept) state_d = BEAT0;
      BEAT0:   if (out_ready_i) state_d = BEAT1;
      BEAT1:   if (out_ready_i) state_d = accept ? BEAT0 : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d   = cplx_a_i;
      b_d   = cplx_b_i;
      tag_d = tag_i;
`ifdef COMPLEX_OPERAND_SEQ_CONJ_EN
      b_d[0][63] = cplx_b_i[0][63] ^ conj_i;
`endif
    end

    if (flush_i) state_d = IDLE;
  end

  // Output packing straight from the held registers; bits pass through untouched.
  always_comb begin
    out_valid_o = (state_q != IDLE);
    busy_o      = (state_q != IDLE);
    beat_o      = (state_q == BEAT1);
    tag_o       = tag_q;
    if (state_q == BEAT1) operands_o = {a_q[1], a_q[0], b_q[0], b_q[1]};
    else                  operands_o = {a_q[1], a_q[0], b_q[1], b_q[0]};
  end

endmodule
